// File: rtl/dct_reorder_in.sv
// Makhoul even/odd input reorder for the DCT-via-FFT path.
// Ping-pong banks: one frame is written while the other streams to the FFT.
`timescale 1ns/1ps
module dct_reorder_in #(
    parameter int DW         = 16,
    parameter int LOG2_MAX_N = 11,
    parameter int PW         = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sink_valid,
    output logic          sink_ready,
    input  logic          sink_sop,
    input  logic          sink_eop,
    input  logic [1:0]    sink_error,
    input  logic [DW-1:0] sink_data,
    input  logic [PW-1:0] fftpts_in,
    output logic          source_valid,
    input  logic          source_ready,
    output logic          source_sop,
    output logic          source_eop,
    output logic [1:0]    source_error,
    output logic [DW-1:0] source_real,
    output logic [DW-1:0] source_imag,
    output logic [PW-1:0] fftpts_out
);
    localparam int AW = LOG2_MAX_N;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [DW-1:0] mem [0:2**(AW+1)-1];

    logic [1:0]    state;
    logic [1:0]    full;
    logic          wb, rb, en;
    logic [AW-1:0] wcnt;
    logic [PW-1:0] n_w;
    logic [1:0]    err_w;
    logic [PW-1:0] n_bank [2];
    logic [1:0]    err_bank [2];

    logic          accept, n_legal, last_k, eop_bad, we, done;
    logic [AW-1:0] nm1_w, waddr;
    logic [1:0]    err_nxt, full_set, full_clr;

    logic [AW-1:0] raddr, nm1_r;
    logic          rd_done, rd, pop, rel, issue_ok, move;
    logic          qv, q_sop, q_eop;
    logic          sv, s_sop, s_eop;
    logic [DW-1:0] q_data, s_data;

    always_comb begin
        sink_ready = en & ((state == S_DROP) | ~full[wb]);
        accept     = sink_valid & sink_ready;
        n_legal    = (fftpts_in >= PW'(8)) && (fftpts_in <= PW'(2**AW)) &&
                     ((fftpts_in & (fftpts_in - PW'(1))) == '0);
        nm1_w      = n_w[AW-1:0] - AW'(1);
        last_k     = (wcnt == nm1_w);
        eop_bad    = sink_eop ^ last_k;
        err_nxt    = err_w | sink_error | {1'b0, eop_bad};
        // Even samples fill from the front, odd samples from the back.
        if (sink_sop)
            waddr = '0;
        else if (wcnt[0])
            waddr = nm1_w - (wcnt >> 1);
        else
            waddr = wcnt >> 1;
        we   = accept & (((state != S_DROP) & sink_sop & n_legal) |
                         ((state == S_WRITE) & ~sink_sop));
        done = accept & (state == S_WRITE) & ~sink_sop & last_k;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            wcnt  <= '0;
            n_w   <= '0;
            err_w <= '0;
            wb    <= 1'b0;
            en    <= 1'b0;
        end else begin
            en <= 1'b1;
            if (accept) begin
                case (state)
                    S_IDLE, S_WRITE: begin
                        if (sink_sop) begin
                            if (n_legal) begin
                                n_w   <= fftpts_in;
                                err_w <= sink_error | {1'b0, sink_eop};
                                wcnt  <= AW'(1);
                                state <= S_WRITE;
                            end else begin
                                state <= sink_eop ? S_IDLE : S_DROP;
                            end
                        end else if (state == S_WRITE) begin
                            err_w <= err_nxt;
                            wcnt  <= wcnt + AW'(1);
                            if (last_k) begin
                                wb    <= ~wb;
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_DROP: if (sink_eop) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[{wb, waddr}] <= sink_data;
    end

    always_comb begin
        full_set = done ? (2'b01 << wb) : 2'b00;
        full_clr = rel ? (2'b01 << rb) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full        <= '0;
            n_bank[0]   <= '0;
            n_bank[1]   <= '0;
            err_bank[0] <= '0;
            err_bank[1] <= '0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (done) begin
                n_bank[wb]   <= n_w;
                err_bank[wb] <= err_nxt;
            end
        end
    end

    // q is the RAM output register, s the skid; s is older when both valid.
    always_comb begin
        source_valid = sv | qv;
        source_real  = sv ? s_data : q_data;
        source_sop   = sv ? s_sop : (qv & q_sop);
        source_eop   = sv ? s_eop : (qv & q_eop);
        source_imag  = '0;
        fftpts_out   = source_valid ? n_bank[rb] : '0;
        source_error = source_valid ? err_bank[rb] : '0;
        nm1_r        = n_bank[rb][AW-1:0] - AW'(1);
        pop          = source_valid & source_ready;
        rel          = pop & source_eop;
        issue_ok     = ~(sv & qv & ~pop);
        rd           = full[rb] & ~rd_done & issue_ok;
        move         = rd & qv & ~(~sv & pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qv      <= 1'b0;
            sv      <= 1'b0;
            q_data  <= '0;
            q_sop   <= 1'b0;
            q_eop   <= 1'b0;
            s_data  <= '0;
            s_sop   <= 1'b0;
            s_eop   <= 1'b0;
            raddr   <= '0;
            rd_done <= 1'b0;
            rb      <= 1'b0;
        end else begin
            if (rd) begin
                q_data <= mem[{rb, raddr}];
                q_sop  <= (raddr == '0);
                q_eop  <= (raddr == nm1_r);
                raddr  <= raddr + AW'(1);
                if (raddr == nm1_r) rd_done <= 1'b1;
            end
            if (move) begin
                s_data <= q_data;
                s_sop  <= q_sop;
                s_eop  <= q_eop;
            end
            qv <= rd | (qv & ~(~sv & pop));
            sv <= move | (sv & ~pop);
            if (rel) begin
                rb      <= ~rb;
                raddr   <= '0;
                rd_done <= 1'b0;
            end
        end
    end
endmodule
